fifo_stream_reader: RTL and testbench

// Downstream read stage for the synchronous FIFO (fifo). Issues rd_en into the FIFO,

---
 rtl/fifo_stream_reader.sv | 105 ++++++++++
 tb/tb_fifo_stream_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read stage behind the synchronous FIFO. Issues fifo_rd_en and captures
//   fifo_dout one cycle later into a 2-entry buffer. Presents the buffered
//   words on a valid/ready stream at one word per cycle without bubbles.
//   A read is issued only when the buffer has room for the word. That count
//   includes the word already in flight and a pop in the current cycle.
//   Optional feature macro: FIFO_RD_LAST_EN adds m_last, a per-packet beat
//   marker that repeats every PKT_LEN accepted words.
module fifo_stream_reader #(
   parameter int WIDTH   = 8,
   parameter int PKT_LEN = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_dout,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic [1:0]       buf_cnt
`ifdef FIFO_RD_LAST_EN
   ,
   output logic             m_last
`endif
);

   // Packet length must allow a counter of at least one bit.
   if (PKT_LEN < 2) begin : g_pkt_len_check
      $error("fifo_stream_reader: PKT_LEN must be >= 2");
   end

   logic             r_inflight;
   logic [WIDTH-1:0] r_buf [2];
   logic             r_wptr;
   logic             r_rptr;
   logic [1:0]       r_cnt;
   logic             w_pop;
   logic [2:0]       w_credit;

   assign m_valid = (r_cnt != 2'd0);
   assign w_pop   = m_valid & m_ready;

   // Occupancy after this cycle's pop, counting the word still in flight.
   // A pop implies r_cnt >= 1, so this never underflows.
   assign w_credit   = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign fifo_rd_en = rst_n & ~fifo_empty & (w_credit < 3'd2);

   // Head of the buffer is a register, so there is no path from fifo_dout.
   assign m_data  = r_buf[r_rptr];
   assign buf_cnt = r_cnt;

   // Track whether the FIFO returns a word at the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= fifo_rd_en;
      end
   end

   // Capture returning words at the tail and retire popped words at the head.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf[0] <= '0;
         r_buf[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_cnt    <= 2'd0;
      end else begin
         if (r_inflight) begin
            r_buf[r_wptr] <= fifo_dout;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({r_inflight, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

`ifdef FIFO_RD_LAST_EN
   localparam int               BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0]    LAST_BEAT = BW'(PKT_LEN - 1);

   logic [BW-1:0] r_beat;

   // Count accepted beats within the packet, wrapping after the last one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_beat <= '0;
      end else if (w_pop) begin
         r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + BW'(1);
      end
   end

   // The beat count only moves on pop, so m_last stays stable with m_data.
   assign m_last = m_valid & (r_beat == LAST_BEAT);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Drives fifo_stream_reader from a behavioural synchronous FIFO model. Each
//   word written into the model is queued as expected output. A negedge
//   monitor pops and compares accepted words and checks hold-while-stalled.
//   It also collects read/valid statistics for the directed checks.
module tb_fifo_stream_reader;

   localparam int WIDTH   = 8;
   localparam int PKT_LEN = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             fifo_empty;
   logic             fifo_rd_en;
   logic [WIDTH-1:0] fifo_dout;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [WIDTH-1:0] m_data;
   logic [1:0]       buf_cnt;
`ifdef FIFO_RD_LAST_EN
   logic             m_last;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic [WIDTH-1:0] exp_q[$];

   always #5 clk = ~clk;

   fifo_stream_reader #(.WIDTH(WIDTH), .PKT_LEN(PKT_LEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_dout  (fifo_dout),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .buf_cnt    (buf_cnt)
`ifdef FIFO_RD_LAST_EN
      ,
      .m_last     (m_last)
`endif
   );

   // Behavioural FIFO: one-cycle read latency, shares rst_n with the DUT.
   logic [WIDTH-1:0] mem [256];
   logic [7:0]       wp, rp;
   logic             wr_en = 1'b0;
   logic [WIDTH-1:0] din = '0;
   logic             hold_nonempty = 1'b0;

   assign fifo_empty = (wp == rp) & ~hold_nonempty;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         fifo_dout <= '0;
      end else begin
         if (wr_en) begin
            mem[wp] <= din;
            wp      <= wp + 8'd1;
         end
         if (fifo_rd_en) begin
            fifo_dout <= mem[rp];
            rp        <= rp + 8'd1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int rd_pulses = 0, rd_cyc = -1, v_cycles = 0, v_cyc = -1, run = 0, max_run = 0;
   int beat = 0;
   logic stall_prev = 1'b0;
   logic [WIDTH-1:0] data_prev = '0;

   // Monitor: scoreboard pops, stall stability, X check, statistics.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
         beat       = 0;
         run        = 0;
      end else begin
         if (fifo_rd_en) begin
            rd_pulses++;
            if (rd_cyc < 0) rd_cyc = cyc;
         end
         if (m_valid) begin
            v_cycles++;
            if (v_cyc < 0) v_cyc = cyc;
            run++;
            if (run > max_run) max_run = run;
            check("x_on_data", 32'($isunknown(m_data)), 0);
`ifdef FIFO_RD_LAST_EN
            check("m_last", m_last, (beat == PKT_LEN - 1) ? 1 : 0);
`endif
         end else begin
            run = 0;
         end
         if (stall_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, data_prev);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL pop_unexpected: got 0x%0h, expected no word", m_data);
            end else begin
               check("pop_data", m_data, exp_q.pop_front());
            end
            beat = (beat == PKT_LEN - 1) ? 0 : beat + 1;
         end
         stall_prev = m_valid && !m_ready;
         data_prev  = m_data;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         assert (buf_cnt <= 2'd2)
         else $error("FAIL buf_cnt_bound: got %0d, required <= 2", buf_cnt);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [WIDTH-1:0] d);
      wr_en = 1'b1;
      din   = d;
      exp_q.push_back(d);
      step();
   endtask

   task automatic clear_stats();
      rd_pulses = 0; rd_cyc = -1; v_cycles = 0; v_cyc = -1; max_run = 0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || m_valid) && n < budget) begin
         step();
         n++;
      end
      check("drain_remaining", exp_q.size(), 0);
      check("drain_buf_cnt", buf_cnt, 0);
   endtask

   initial begin
      // Reset held with a non-empty FIFO and ready downstream.
      hold_nonempty = 1'b1;
      m_ready       = 1'b1;
      rst_n         = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("rst_rd_en", fifo_rd_en, 0);
         check("rst_valid", m_valid, 0);
         check("rst_data", m_data, 0);
         check("rst_buf_cnt", buf_cnt, 0);
      end
      hold_nonempty = 1'b0;
      step();
      rst_n = 1'b1;
      step();

      // Single word.
      clear_stats();
      write_word(8'hA5);
      wr_en = 1'b0;
      repeat (6) step();
      check("single_rd_pulses", rd_pulses, 1);
      check("single_valid_cycles", v_cycles, 1);
      check("single_latency", v_cyc - rd_cyc, 2);
      check("single_buf_cnt", buf_cnt, 0);

      // Backpressure: only two reads may be issued.
      m_ready = 1'b0;
      clear_stats();
      for (int i = 0; i < 8; i++) write_word(8'(i));
      wr_en = 1'b0;
      repeat (8) step();
      @(negedge clk);
      check("bp_rd_pulses", rd_pulses, 2);
      check("bp_buf_cnt", buf_cnt, 2);
      check("bp_valid", m_valid, 1);
      check("bp_head", m_data, 8'h00);
      check("bp_rd_en_low", fifo_rd_en, 0);
      step();
      m_ready = 1'b1;
      drain(40);

      // Streaming: one word per cycle with no bubble.
      clear_stats();
      for (int i = 0; i < 8; i++) write_word(8'h10 + 8'(i));
      wr_en = 1'b0;
      drain(40);
      check("stream_valid_cycles", v_cycles, 8);
      check("stream_run", max_run, 8);

      // Random writes and random backpressure.
      for (int i = 0; i < 100; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         din     = 8'($urandom_range(0, 255));
         if (wr_en) exp_q.push_back(din);
         m_ready = 1'($urandom_range(0, 1));
         step();
      end
      wr_en   = 1'b0;
      m_ready = 1'b1;
      drain(400);

      // Reset while the buffer is full.
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i));
      wr_en = 1'b0;
      begin
         int n = 0;
         while (buf_cnt != 2'd2 && n < 20) begin
            step();
            n++;
         end
         check("mid_rst_fill", buf_cnt, 2);
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_rd_en", fifo_rd_en, 0);
      check("mid_rst_valid", m_valid, 0);
      check("mid_rst_data", m_data, 0);
      check("mid_rst_buf_cnt", buf_cnt, 0);
      exp_q.delete();
      step();
      rst_n   = 1'b1;
      m_ready = 1'b1;
      step();
      clear_stats();
      write_word(8'h5A);
      wr_en = 1'b0;
      drain(20);
      check("post_rst_valid_cycles", v_cycles, 1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
